// File: rtl/name_tile_fetch.sv
// Scanline tile fetcher: name ROM -> glyph ROM -> one glyph row byte per tile column,
// streamed to the pixel serializer over valid/ready.
module name_tile_fetch #(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned COLS           = 80,
  parameter int unsigned COL_WIDTH      = 7,
  parameter int unsigned TILE_ROWS_LOG2 = 3,
  parameter int unsigned Y_WIDTH        = 10
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 line_start,
  input  logic [Y_WIDTH-1:0]                   line_y,
  output logic                                 busy,
  output logic                                 line_done,
  output logic [ADDR_WIDTH-1:0]                name_addr,
  input  logic [DATA_WIDTH-1:0]                name_rdata,
  output logic [DATA_WIDTH+TILE_ROWS_LOG2-1:0] glyph_addr,
  input  logic [7:0]                           glyph_rdata,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [7:0]                           out_data,
  output logic [COL_WIDTH-1:0]                 out_col
);

  localparam int unsigned ROW_WIDTH  = Y_WIDTH - TILE_ROWS_LOG2;
  localparam int unsigned COLS_WIDTH = $clog2(COLS + 1);
  localparam int unsigned PROD_WIDTH = ROW_WIDTH + COLS_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    N_REQ = 3'd1,
    N_CAP = 3'd2,
    G_REQ = 3'd3,
    G_CAP = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t                    state;
  logic [COL_WIDTH-1:0]      col;
  logic [ADDR_WIDTH-1:0]     base;
  logic [TILE_ROWS_LOG2-1:0] sub;

  logic [ROW_WIDTH-1:0]  tile_row_c;
  logic [PROD_WIDTH-1:0] row_prod_c;
  logic [ADDR_WIDTH-1:0] base_c;
  logic [ADDR_WIDTH-1:0] next_addr_c;
  logic                  last_col_c;

  // Row base address in the name table; wraps silently at the ROM size.
  assign tile_row_c  = line_y[Y_WIDTH-1:TILE_ROWS_LOG2];
  assign row_prod_c  = PROD_WIDTH'(tile_row_c) * PROD_WIDTH'(COLS);
  assign base_c      = ADDR_WIDTH'(row_prod_c);
  assign next_addr_c = base + ADDR_WIDTH'(col) + ADDR_WIDTH'(1);
  assign last_col_c  = (col == COL_WIDTH'(COLS - 1));

  // Fetch sequencer; line_start restarts from any state, reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      line_done  <= 1'b0;
      name_addr  <= '0;
      glyph_addr <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_col    <= '0;
      col        <= '0;
      base       <= '0;
      sub        <= '0;
    end else begin
      line_done <= 1'b0;
      if (line_start) begin
        state     <= N_REQ;
        busy      <= 1'b1;
        sub       <= line_y[TILE_ROWS_LOG2-1:0];
        base      <= base_c;
        col       <= '0;
        name_addr <= base_c;
        out_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE:  state <= IDLE;
          N_REQ: state <= N_CAP;
          N_CAP: begin
            glyph_addr <= {name_rdata, sub};
            state      <= G_REQ;
          end
          G_REQ: state <= G_CAP;
          G_CAP: begin
            out_data  <= glyph_rdata;
            out_col   <= col;
            out_valid <= 1'b1;
            state     <= OUT;
          end
          OUT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (last_col_c) begin
                line_done <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
              end else begin
                col       <= col + COL_WIDTH'(1);
                name_addr <= next_addr_c;
                state     <= N_REQ;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_name_tile_fetch.sv
// Scoreboard bench for name_tile_fetch: random ROM contents, randomized lines/backpressure/aborts.
module tb_name_tile_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [9:0]  line_y;
  logic        busy;
  logic        line_done;
  logic [10:0] name_addr;
  logic [7:0]  name_rdata;
  logic [10:0] glyph_addr;
  logic [7:0]  glyph_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [6:0]  out_col;

  name_tile_fetch dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_y(line_y),
    .busy(busy), .line_done(line_done), .name_addr(name_addr), .name_rdata(name_rdata),
    .glyph_addr(glyph_addr), .glyph_rdata(glyph_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_col(out_col)
  );

  always #5 clk = ~clk;

  logic [7:0] name_mem  [2048];
  logic [7:0] glyph_mem [2048];

  // Registered-output ROM models
  always @(posedge clk) begin
    name_rdata  <= name_mem[name_addr];
    glyph_rdata <= glyph_mem[glyph_addr];
  end

  typedef struct {
    int col;
    int data;
    int naddr;
  } beat_t;

  beat_t sbq[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    done_cyc = 0;
  bit    done_pending = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake, checks hold under backpressure and line_done
  bit         hold_pend = 0;
  bit         ls_prev = 0;
  logic [7:0] hold_data;
  logic [6:0] hold_col;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      hold_pend = 0;
      ls_prev   = 0;
    end else begin
      if (hold_pend && !ls_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
        chk("hold_col", out_col, hold_col);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("out_col", out_col, e.col);
          chk("out_data", out_data, e.data);
          chk("name_addr_beat", name_addr, e.naddr);
        end
      end
      if (line_done) begin
        chk("done_expected", done_pending, 1);
        chk("done_beats_left", sbq.size(), 0);
        chk("done_busy", busy, 0);
        done_pending = 0;
        done_cyc     = cyc;
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_col  = out_col;
      ls_prev   = line_start;
    end
  end

  // Reference: the 80 beats a line must produce, from the addressing rules alone
  task automatic start_line(input int y);
    int base;
    beat_t e;
    logic [10:0] a;
    logic [10:0] ga;
    base = ((y / 8) * 80) % 2048;
    sbq.delete();
    for (int c = 0; c < 80; c++) begin
      a       = 11'((base + c) % 2048);
      ga      = {name_mem[a], 3'(y % 8)};
      e.col   = c;
      e.data  = glyph_mem[ga];
      e.naddr = a;
      sbq.push_back(e);
    end
    done_pending = 1;
    line_start   = 1'b1;
    line_y       = 10'(y);
    out_ready    = 1'b0;
    @(posedge clk);
    #1;
    start_cyc  = cyc;
    line_start = 1'b0;
  endtask

  // mode 0: ready always; mode 1: random ready. hold_col: 3 stall cycles there. abort_col<0: none
  task automatic run_line(input int y, input int mode, input int hold_col,
                          input int abort_col, input int abort_y);
    int  hold_cnt = 0;
    int  t = 0;
    bit  aborted = 0;
    start_line(y);
    while (done_pending && t < 3000) begin
      out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && int'(out_col) == hold_col && hold_cnt < 3) begin
        out_ready = 1'b0;
        hold_cnt++;
      end
      if (!aborted && abort_col >= 0 && out_valid && int'(out_col) == abort_col) begin
        aborted = 1;
        start_line(abort_y);
        chk("abort_valid_drop", out_valid, 0);
        chk("abort_name_addr", name_addr, ((abort_y / 8) * 80) % 2048);
      end else begin
        @(posedge clk);
        #1;
      end
      t++;
    end
    if (done_pending) chk("line_timeout", 0, 1);
  endtask

  initial begin
    int k;
    int y;
    int ac;
    for (int i = 0; i < 2048; i++) begin
      name_mem[i]  = 8'($urandom);
      glyph_mem[i] = 8'($urandom);
    end
    rst_n      = 1'b0;
    line_start = 1'b1;
    line_y     = 10'd17;
    out_ready  = 1'b1;

    // Reset holds IDLE even with line_start asserted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_name_addr", name_addr, 0);
    chk("rst_glyph_addr", glyph_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_col", out_col, 0);
    rst_n      = 1'b1;
    line_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);

    // Full line y=17 with ready high: addressing, latency, 400-cycle line time
    start_line(17);
    chk("first_name_addr", name_addr, 160);
    chk("busy_running", busy, 1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("first_glyph_addr", glyph_addr, {name_mem[160], 3'd1});
    k = 2;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("first_valid_latency", k, 4);
    k = 0;
    while (done_pending && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("line_cycles", done_cyc - start_cyc, 400);
    @(posedge clk);
    #1;
    chk("after_done_busy", busy, 0);
    chk("after_done_pulse", line_done, 0);

    // Backpressure at col 5
    run_line(42, 0, 5, -1, 0);
    // Name-table wrap cases
    run_line(199, 0, -1, -1, 0);
    run_line(207, 0, -1, -1, 0);
    // Abort at col 10 into line y=8
    run_line(100, 0, -1, 10, 8);

    // Reset mid-line at col 40
    start_line(300);
    out_ready = 1'b1;
    k = 0;
    while (!(out_valid && out_col == 7'd40) && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reached_col40", out_col, 40);
    rst_n     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_line_done", line_done, 0);
    chk("mid_rst_name_addr", name_addr, 0);
    chk("mid_rst_glyph_addr", glyph_addr, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_col", out_col, 0);
    rst_n = 1'b1;
    sbq.delete();
    done_pending = 0;
    out_ready    = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", out_valid, 0);

    // Randomized lines, backpressure and aborts
    for (int r = 0; r < 6; r++) begin
      y  = $urandom_range(0, 1023);
      ac = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 79)) : -1;
      run_line(y, 1, -1, ac, $urandom_range(0, 1023));
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
